// File: rtl/aes_byte_loader.sv
`timescale 1ns/1ps
// aes_byte_loader
// Byte-serial front end for the AES datapath. Assembles a 4*NK-byte key
// and then 16-byte data blocks from a valid/ready byte stream. Each
// complete block is presented in parallel and held until it is acknowledged.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   in_byte    stream byte; the first byte of a phase is the most significant
//   in_valid   in_byte is valid
//   in_ready   loader accepts a byte this cycle (low while a block is held)
//   clear      synchronous restart: drops the key and any partial block
//   new_key    sampled with blk_ack: 1 = load a fresh key before the next block
//   key_out    assembled key, byte 0 in [KW-1:KW-8]  (drives KeyExpansion)
//   key_valid  key_out holds a complete key
//   data_out   assembled block, byte 0 in [127:120]  (drives Cipher/DeCipher)
//   blk_valid  data_out is complete and held
//   blk_ack    consumer has taken data_out
//   byte_cnt   bytes accepted in the current key/block phase
module aes_byte_loader #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clear,
  input  logic            new_key,
  output logic [32*NK-1:0] key_out,
  output logic            key_valid,
  output logic [127:0]    data_out,
  output logic            blk_valid,
  input  logic            blk_ack,
  output logic [5:0]      byte_cnt
);

  localparam int          KW       = 32 * NK;
  localparam logic [5:0]  KEY_LAST = 6'(4 * NK - 1);
  localparam logic [5:0]  BLK_LAST = 6'd15;

  typedef enum logic [1:0] {
    S_KEY  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_in_ready;
  logic [5:0]        r_cnt;
  logic [KW-1:0]     r_sh_key;
  logic [127:0]      r_sh_dat;
  logic [KW-1:0]     r_key_out;
  logic              r_key_valid;
  logic [127:0]      r_data_out;
  logic              r_blk_valid;

  logic              w_accept;
  logic              w_key_byte;
  logic              w_dat_byte;
  logic              w_key_done;
  logic              w_blk_done;
  logic              w_ack_take;
  logic [KW-1:0]     w_key_shift;
  logic [127:0]      w_dat_shift;

  // in_ready is registered from the next state, so it is low while reset is
  // held, rises one cycle after release, and is already low in the first
  // cycle of S_HOLD.
  assign w_accept    = in_valid & r_in_ready;
  assign w_key_shift = {r_sh_key[KW-9:0], in_byte};
  assign w_dat_shift = {r_sh_dat[119:0], in_byte};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_KEY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and phase-completion decode; clear overrides everything,
  // including a simultaneous accept or acknowledge.
  always_comb begin
    w_state_nxt = r_state;
    w_key_byte  = 1'b0;
    w_dat_byte  = 1'b0;
    w_key_done  = 1'b0;
    w_blk_done  = 1'b0;
    w_ack_take  = 1'b0;
    if (clear) begin
      w_state_nxt = S_KEY;
    end else begin
      case (r_state)
        S_KEY: begin
          if (w_accept) begin
            w_key_byte = 1'b1;
            if (r_cnt == KEY_LAST) begin
              w_key_done  = 1'b1;
              w_state_nxt = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            w_dat_byte = 1'b1;
            if (r_cnt == BLK_LAST) begin
              w_blk_done  = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (blk_ack) begin
            w_ack_take  = 1'b1;
            w_state_nxt = new_key ? S_KEY : S_DATA;
          end
        end
        default: begin
          w_state_nxt = S_KEY;
        end
      endcase
    end
  end

  // Handshake and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_ready <= 1'b0;
      r_cnt      <= 6'd0;
    end else begin
      r_in_ready <= (w_state_nxt != S_HOLD);
      if (clear || w_key_done || w_blk_done) begin
        r_cnt <= 6'd0;
      end else if (w_key_byte || w_dat_byte) begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  // Shift registers collect bytes; outputs update only on phase completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_key <= '0;
      r_sh_dat <= '0;
    end else if (clear) begin
      r_sh_key <= '0;
      r_sh_dat <= '0;
    end else begin
      if (w_key_byte) begin
        r_sh_key <= w_key_shift;
      end
      if (w_dat_byte) begin
        r_sh_dat <= w_dat_shift;
      end
    end
  end

  // Parallel outputs and their valid flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_data_out  <= '0;
      r_blk_valid <= 1'b0;
    end else if (clear) begin
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_data_out  <= '0;
      r_blk_valid <= 1'b0;
    end else begin
      if (w_key_done) begin
        r_key_out   <= w_key_shift;
        r_key_valid <= 1'b1;
      end
      if (w_blk_done) begin
        r_data_out  <= w_dat_shift;
        r_blk_valid <= 1'b1;
      end
      if (w_ack_take) begin
        r_blk_valid <= 1'b0;
        // key_out itself is kept until the next key overwrites it
        if (new_key) begin
          r_key_valid <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign byte_cnt  = r_cnt;
  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign data_out  = r_data_out;
  assign blk_valid = r_blk_valid;

endmodule

// File: tb/tb_aes_byte_loader.sv
`timescale 1ns/1ps
// Directed bench for aes_byte_loader: one NK=4 instance and one NK=8 instance.
module tb_aes_byte_loader;

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KF0  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         clear = 1'b0;
  logic         new_key = 1'b0;
  logic [127:0] key_out;
  logic         key_valid;
  logic [127:0] data_out;
  logic         blk_valid;
  logic         blk_ack = 1'b0;
  logic [5:0]   byte_cnt;

  logic [7:0]   b8 = 8'h00;
  logic         v8 = 1'b0;
  logic         rdy8;
  logic         ack8 = 1'b0;
  logic [255:0] key8;
  logic         kv8;
  logic [127:0] dat8;
  logic         bv8;
  logic [5:0]   cnt8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_byte_loader #(.NK(4)) u4 (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .new_key(new_key), .key_out(key_out),
    .key_valid(key_valid), .data_out(data_out), .blk_valid(blk_valid),
    .blk_ack(blk_ack), .byte_cnt(byte_cnt)
  );

  aes_byte_loader #(.NK(8)) u8 (
    .clk(clk), .reset(reset), .in_byte(b8), .in_valid(v8),
    .in_ready(rdy8), .clear(1'b0), .new_key(1'b0), .key_out(key8),
    .key_valid(kv8), .data_out(dat8), .blk_valid(bv8),
    .blk_ack(ack8), .byte_cnt(cnt8)
  );

  // Present one byte at a negedge and return at the negedge after it is taken.
  task automatic send(input bit s8, input logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    if (s8) begin b8 = b; v8 = 1'b1; end
    else begin in_byte = b; in_valid = 1'b1; end
    while (!(s8 ? rdy8 : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdy = s8 ? rdy8 : in_ready;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $error("FAIL ready_wait observed=%0h expected=%0h", rdy, 1'b1);
    end
    @(negedge clk);
    v8 = 1'b0;
    in_valid = 1'b0;
  endtask

  // Stream the first nb bytes of v (MSB first), optionally with idle gaps
  // during which the byte counter must not move.
  task automatic send_vec(input bit s8, input logic [255:0] v, input int nb,
                          input int first, input int last, input bit gaps);
    logic [5:0] held;
    int g;
    for (int i = first; i < last; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        held = byte_cnt;
        repeat (g) @(negedge clk);
        if (g > 0) begin
          checks++;
          if (byte_cnt !== held) begin
            errors++;
            $error("FAIL gap_hold observed=%0h expected=%0h", byte_cnt, held);
          end
        end
      end
      send(s8, v[8*(nb-1-i) +: 8]);
    end
  endtask

  task automatic ack(input logic nk);
    blk_ack = 1'b1;
    new_key = nk;
    @(negedge clk);
    blk_ack = 1'b0;
    new_key = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $error("FAIL rst_ready observed=%0h expected=%0h", in_ready, 1'b0); end
    checks++;
    if (byte_cnt !== 6'd0) begin errors++; $error("FAIL rst_cnt observed=%0h expected=%0h", byte_cnt, 6'd0); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $error("FAIL rst_kv observed=%0h expected=%0h", key_valid, 1'b0); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $error("FAIL rst_bv observed=%0h expected=%0h", blk_valid, 1'b0); end
    checks++;
    if (key_out !== 128'h0) begin errors++; $error("FAIL rst_key observed=%0h expected=%0h", key_out, 128'h0); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $error("FAIL rel_ready observed=%0h expected=%0h", in_ready, 1'b1); end

    // Test 1: key then block, in_valid continuous
    send_vec(1'b0, {128'h0, K128}, 16, 0, 15, 1'b0);
    checks++;
    if (byte_cnt !== 6'd15) begin errors++; $error("FAIL t1_cnt15 observed=%0h expected=%0h", byte_cnt, 6'd15); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $error("FAIL t1_kv_early observed=%0h expected=%0h", key_valid, 1'b0); end
    send_vec(1'b0, {128'h0, K128}, 16, 15, 16, 1'b0);
    checks++;
    if (key_valid !== 1'b1) begin errors++; $error("FAIL t1_kv observed=%0h expected=%0h", key_valid, 1'b1); end
    checks++;
    if (key_out !== K128) begin errors++; $error("FAIL t1_key observed=%0h expected=%0h", key_out, K128); end
    checks++;
    if (byte_cnt !== 6'd0) begin errors++; $error("FAIL t1_cnt0 observed=%0h expected=%0h", byte_cnt, 6'd0); end
    send_vec(1'b0, {128'h0, PT}, 16, 0, 15, 1'b0);
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $error("FAIL t1_bv_early observed=%0h expected=%0h", blk_valid, 1'b0); end
    send_vec(1'b0, {128'h0, PT}, 16, 15, 16, 1'b0);
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $error("FAIL t1_bv observed=%0h expected=%0h", blk_valid, 1'b1); end
    checks++;
    if (data_out !== PT) begin errors++; $error("FAIL t1_data observed=%0h expected=%0h", data_out, PT); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $error("FAIL t1_hold_rdy observed=%0h expected=%0h", in_ready, 1'b0); end
    // bytes offered while holding must be ignored
    in_byte = 8'haa;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (byte_cnt !== 6'd0) begin errors++; $error("FAIL t1_hold_cnt observed=%0h expected=%0h", byte_cnt, 6'd0); end
    checks++;
    if (data_out !== PT) begin errors++; $error("FAIL t1_hold_data observed=%0h expected=%0h", data_out, PT); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $error("FAIL t1_hold_bv observed=%0h expected=%0h", blk_valid, 1'b1); end

    // Test 2: ack without new key, back-to-back next block
    ack(1'b0);
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $error("FAIL t2_bv_off observed=%0h expected=%0h", blk_valid, 1'b0); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $error("FAIL t2_rdy observed=%0h expected=%0h", in_ready, 1'b1); end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $error("FAIL t2_kv observed=%0h expected=%0h", key_valid, 1'b1); end
    send_vec(1'b0, {128'h0, CT}, 16, 0, 16, 1'b0);
    checks++;
    if (data_out !== CT) begin errors++; $error("FAIL t2_data observed=%0h expected=%0h", data_out, CT); end
    checks++;
    if (key_out !== K128) begin errors++; $error("FAIL t2_key observed=%0h expected=%0h", key_out, K128); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $error("FAIL t2_bv observed=%0h expected=%0h", blk_valid, 1'b1); end

    // Test 5: ack with new key, reload key
    ack(1'b1);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $error("FAIL t5_kv_off observed=%0h expected=%0h", key_valid, 1'b0); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $error("FAIL t5_rdy observed=%0h expected=%0h", in_ready, 1'b1); end
    checks++;
    if (key_out !== K128) begin errors++; $error("FAIL t5_key_kept observed=%0h expected=%0h", key_out, K128); end
    send_vec(1'b0, {128'h0, KF0}, 16, 0, 16, 1'b0);
    checks++;
    if (key_out !== KF0) begin errors++; $error("FAIL t5_key observed=%0h expected=%0h", key_out, KF0); end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $error("FAIL t5_kv observed=%0h expected=%0h", key_valid, 1'b1); end
    // ack outside the hold state is ignored
    send_vec(1'b0, {128'h0, PT}, 16, 0, 4, 1'b0);
    ack(1'b1);
    checks++;
    if (byte_cnt !== 6'd4) begin errors++; $error("FAIL t5_ack_ign_cnt observed=%0h expected=%0h", byte_cnt, 6'd4); end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $error("FAIL t5_ack_ign_kv observed=%0h expected=%0h", key_valid, 1'b1); end
    send_vec(1'b0, {128'h0, PT}, 16, 4, 16, 1'b0);
    checks++;
    if (data_out !== PT) begin errors++; $error("FAIL t5_data observed=%0h expected=%0h", data_out, PT); end

    // Test 6a: clear together with the 11th data byte
    ack(1'b0);
    send_vec(1'b0, {128'h0, CT}, 16, 0, 10, 1'b0);
    checks++;
    if (byte_cnt !== 6'd10) begin errors++; $error("FAIL t6_cnt10 observed=%0h expected=%0h", byte_cnt, 6'd10); end
    in_byte = 8'h55;
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (byte_cnt !== 6'd0) begin errors++; $error("FAIL t6_clr_cnt observed=%0h expected=%0h", byte_cnt, 6'd0); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $error("FAIL t6_clr_kv observed=%0h expected=%0h", key_valid, 1'b0); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $error("FAIL t6_clr_bv observed=%0h expected=%0h", blk_valid, 1'b0); end
    checks++;
    if (key_out !== 128'h0) begin errors++; $error("FAIL t6_clr_key observed=%0h expected=%0h", key_out, 128'h0); end
    checks++;
    if (data_out !== 128'h0) begin errors++; $error("FAIL t6_clr_data observed=%0h expected=%0h", data_out, 128'h0); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $error("FAIL t6_clr_rdy observed=%0h expected=%0h", in_ready, 1'b1); end

    // Test 4: gapped load after clear (starts in key phase)
    send_vec(1'b0, {128'h0, K128}, 16, 0, 16, 1'b1);
    checks++;
    if (key_out !== K128) begin errors++; $error("FAIL t4_key observed=%0h expected=%0h", key_out, K128); end
    checks++;
    if (key_valid !== 1'b1) begin errors++; $error("FAIL t4_kv observed=%0h expected=%0h", key_valid, 1'b1); end
    send_vec(1'b0, {128'h0, PT}, 16, 0, 16, 1'b1);
    checks++;
    if (data_out !== PT) begin errors++; $error("FAIL t4_data observed=%0h expected=%0h", data_out, PT); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $error("FAIL t4_bv observed=%0h expected=%0h", blk_valid, 1'b1); end

    // Test 6b: asynchronous reset in the middle of a key
    ack(1'b1);
    send_vec(1'b0, {128'h0, KF0}, 16, 0, 5, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (byte_cnt !== 6'd0) begin errors++; $error("FAIL t6_ar_cnt observed=%0h expected=%0h", byte_cnt, 6'd0); end
    checks++;
    if (key_out !== 128'h0) begin errors++; $error("FAIL t6_ar_key observed=%0h expected=%0h", key_out, 128'h0); end
    checks++;
    if (data_out !== 128'h0) begin errors++; $error("FAIL t6_ar_data observed=%0h expected=%0h", data_out, 128'h0); end
    checks++;
    if (blk_valid !== 1'b0) begin errors++; $error("FAIL t6_ar_bv observed=%0h expected=%0h", blk_valid, 1'b0); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $error("FAIL t6_ar_rdy observed=%0h expected=%0h", in_ready, 1'b0); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $error("FAIL t6_ar_rel_rdy observed=%0h expected=%0h", in_ready, 1'b1); end
    send_vec(1'b0, {128'h0, K128}, 16, 0, 16, 1'b0);
    checks++;
    if (key_out !== K128) begin errors++; $error("FAIL t6_key observed=%0h expected=%0h", key_out, K128); end
    send_vec(1'b0, {128'h0, PT}, 16, 0, 16, 1'b0);
    checks++;
    if (data_out !== PT) begin errors++; $error("FAIL t6_data observed=%0h expected=%0h", data_out, PT); end
    checks++;
    if (blk_valid !== 1'b1) begin errors++; $error("FAIL t6_bv observed=%0h expected=%0h", blk_valid, 1'b1); end

    // Test 3: NK=8 instance
    send_vec(1'b1, K256, 32, 0, 31, 1'b0);
    checks++;
    if (cnt8 !== 6'd31) begin errors++; $error("FAIL t3_cnt31 observed=%0h expected=%0h", cnt8, 6'd31); end
    checks++;
    if (kv8 !== 1'b0) begin errors++; $error("FAIL t3_kv_early observed=%0h expected=%0h", kv8, 1'b0); end
    send_vec(1'b1, K256, 32, 31, 32, 1'b0);
    checks++;
    if (kv8 !== 1'b1) begin errors++; $error("FAIL t3_kv observed=%0h expected=%0h", kv8, 1'b1); end
    checks++;
    if (key8 !== K256) begin errors++; $error("FAIL t3_key observed=%0h expected=%0h", key8, K256); end
    checks++;
    if (cnt8 !== 6'd0) begin errors++; $error("FAIL t3_cnt0 observed=%0h expected=%0h", cnt8, 6'd0); end
    send_vec(1'b1, {128'h0, PT}, 16, 0, 16, 1'b0);
    checks++;
    if (dat8 !== PT) begin errors++; $error("FAIL t3_data observed=%0h expected=%0h", dat8, PT); end
    checks++;
    if (bv8 !== 1'b1) begin errors++; $error("FAIL t3_bv observed=%0h expected=%0h", bv8, 1'b1); end
    checks++;
    if (rdy8 !== 1'b0) begin errors++; $error("FAIL t3_rdy observed=%0h expected=%0h", rdy8, 1'b0); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
